// File: rtl/hex_display_scheduler.sv
// Time-shares one external 4-bit-to-7-segment decoder across NUM_DIGITS displays:
// snapshot a packed hex value, scan it MSD first through the decoder, then commit all digits at once.
module hex_display_scheduler #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] hex_all,
  output logic [1:0]              dbg_state
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Handshake: load is a level request sampled every edge; a request seen while a scan
  // is running is remembered once (pending) and served with the value present at COMMIT.
  state_t                    state_q;
  logic [4*NUM_DIGITS-1:0]   snap_q;
  logic [7*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [7*NUM_DIGITS-1:0]   hex_all_q;
  logic [IW-1:0]             idx_q;
  logic                      lz_q;
  logic                      pending_q;
  logic                      busy_q;
  logic                      done_q;
  logic [3:0]                dec_nibble_q;
  logic [3:0]                cur_nib;
  logic                      blank_now;

  assign cur_nib   = snap_q[4*idx_q +: 4];
  assign blank_now = lz_q && (cur_nib == 4'd0) && (idx_q != '0);

  // Shadow with the digit being captured this cycle folded in, so the final
  // capture and the commit of hex_all happen on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == CAPTURE) begin
      shadow_d[7*idx_q +: 7] = blank_now ? 7'h7F : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      shadow_q     <= '1;
      hex_all_q    <= '1;
      idx_q        <= '0;
      lz_q         <= 1'b0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dec_nibble_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            snap_q  <= value;
            lz_q    <= blank_lz;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (load) pending_q <= 1'b1;
          dec_nibble_q <= cur_nib;
          state_q      <= CAPTURE;
        end
        CAPTURE: begin
          if (load) pending_q <= 1'b1;
          shadow_q <= shadow_d;
          if (!blank_now) lz_q <= 1'b0;
          if (idx_q == '0) begin
            hex_all_q <= shadow_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= COMMIT;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= ISSUE;
          end
        end
        COMMIT: begin
          if (pending_q || load) begin
            pending_q <= 1'b0;
            snap_q    <= value;
            lz_q      <= blank_lz;
            idx_q     <= LAST_IDX;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dec_nibble = dec_nibble_q;
  assign hex_all    = hex_all_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: models the shared decoder, drives directed and random
// scans, and compares against a digit-level display model.
module tb_hex_display_scheduler;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst, load, blank_lz, busy, done;
  logic [4*N-1:0]  value;
  logic [3:0]      dec_nibble;
  logic [6:0]      dec_seg;
  logic [7*N-1:0]  hex_all;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  hex_display_scheduler #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .busy(busy), .done(done), .dec_nibble(dec_nibble), .dec_seg(dec_seg),
    .hex_all(hex_all), .dbg_state(dbg_state)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  // The shared decoder lives outside the DUT.
  assign dec_seg = seg7(dec_nibble);

  // Display model: every digit above the highest nonzero nibble is dark when blanking is on.
  function automatic logic [7*N-1:0] model(input logic [4*N-1:0] v, input logic blz);
    logic [7*N-1:0] r;
    int msd;
    msd = 0;
    for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'd0) msd = k;
    for (int k = 0; k < N; k++) r[7*k +: 7] = (blz && k > msd) ? 7'h7F : seg7(v[4*k +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int             done_cyc, busy_cyc;
  logic           stable_ok;
  logic [4*N-1:0] nib_seq;

  // Cycle c is the low phase after the c-th edge counted from the load edge (c=1 right after it).
  task automatic run_scan(input logic [4*N-1:0] v, input logic blz, input bit scramble);
    logic [7*N-1:0] h0;
    @(negedge clk); value = v; blank_lz = blz; load = 1'b1;
    @(negedge clk); load = 1'b0;
    done_cyc = 0; busy_cyc = 0; stable_ok = 1'b1; nib_seq = '0; h0 = hex_all;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done) done_cyc = c;
      else begin
        if (busy) busy_cyc++;
        if (hex_all !== h0) stable_ok = 1'b0;
        if (c % 2 == 0 && c <= 2*N) nib_seq = {nib_seq[4*N-5:0], dec_nibble};
      end
      if (scramble) value = $urandom;
    end
    value = v;
    chk("done_latency", done_cyc, 17);
    chk("busy_cycles", busy_cyc, 16);
    chk("hex_stable_before_commit", stable_ok, 1);
    chk("nibble_sequence", nib_seq, v);
    chk("hex_all_commit", hex_all, model(v, blz));
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_scan", busy, 0);
  endtask

  int dq[$];
  logic [7*N-1:0] hq[$];
  int busy_between;

  initial begin
    rst = 1'b1; load = 1'b1; value = 32'h1234_5678; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hex_all", hex_all, {7*N{1'b1}});
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dec_nibble", dec_nibble, 0);
    rst = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy, 0);

    run_scan(32'h0000_1234, 1'b0, 1'b0);
    chk("plain_1234", hex_all, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
    run_scan(32'h0000_1234, 1'b1, 1'b0);
    chk("blank_1234", hex_all, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    run_scan(32'h0000_0000, 1'b1, 1'b0);
    chk("blank_zero", hex_all, {{7{7'h7F}}, 7'h40});
    run_scan(32'h8765_4321, 1'b0, 1'b1);

    // Coalesced loads during a scan, value changed before COMMIT.
    @(negedge clk); value = 32'h1357_9BDF; blank_lz = 1'b0; load = 1'b1;
    dq.delete(); hq.delete(); busy_between = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin dq.push_back(c); hq.push_back(hex_all); end
      else if (dq.size() == 1 && busy) busy_between++;
      load = (c == 3 || c == 5 || c == 9);
      if (c == 12) value = 32'hFFFF_FFFF;
    end
    chk("coalesce_done_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("coalesce_first_done", dq[0], 17);
      chk("coalesce_second_done", dq[1], dq[0] + 17);
      chk("coalesce_first_hex", hq[0], model(32'h1357_9BDF, 1'b0));
      chk("coalesce_second_hex", hq[1], {N{7'h0E}});
    end
    chk("coalesce_busy_between", busy_between, 16);

    // Reset mid-scan with a pending load, and load coincident with reset.
    @(negedge clk); value = 32'hABCD_0123; load = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      load = (c == 3 || c == 7);
      rst = (c == 7);
    end
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hex_dark", hex_all, {7*N{1'b1}});
    rst = 1'b0; load = 1'b0;
    dq.delete();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done || busy) dq.push_back(c);
    end
    chk("midrst_no_activity", dq.size(), 0);

    // Load held high: back-to-back scans, one done each.
    @(negedge clk); value = 32'h00C0_FFEE; blank_lz = 1'b1; load = 1'b1;
    dq.delete(); hq.delete();
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      if (done) begin dq.push_back(c); hq.push_back(hex_all); end
    end
    load = 1'b0;
    chk("held_done_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("held_spacing", dq[2] - dq[1], 17);
      chk("held_hex", hq[2], model(32'h00C0_FFEE, 1'b1));
    end
    for (int c = 0; c < 40 && busy !== 1'b0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("held_returns_idle", busy, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rv;
      rv = $urandom >> $urandom_range(0, 31);
      run_scan(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
